// File: rtl/dist_ram_mp.sv
// ---------------------------------------------------------------------------
// dist_ram_mp
//
// Multi-read-port distributed (LUT) RAM with one synchronous write port,
// NRD independent read ports, an optional registered read stage and a
// hardware clear engine that sweeps every word with a fill value.
// Intended for register files, small lookup tables and descriptor stores.
//
// Parameters
//   WIDTH           data bits per word (1..64)
//   DEPTH           number of words (2..256, power of two)
//   NRD             number of read ports (1..8)
//   OUT_REG         0 = asynchronous read, 1 = read data registered
//   WRITE_FIRST     with OUT_REG=1: 1 = same-cycle write bypassed into DO
//   INIT            power-up contents, word i at [i*WIDTH +: WIDTH]
//   CLR_VALUE       word written by the clear engine
//   IS_CLK_INVERTED 1 = all sequential logic runs on the falling edge of CLK
//
// Ports
//   CLK       in   clock
//   RST       in   asynchronous active-high reset (control logic only)
//   WE        in   write enable, ignored while CLR_BUSY=1
//   WADDR     in   write address
//   DI        in   write data
//   RADDR     in   read addresses, port k at [k*AW +: AW]
//   DO        out  read data, port k at [k*WIDTH +: WIDTH]
//   CLR_REQ   in   clear request, level-sampled while idle
//   CLR_BUSY  out  clear sweep in progress
//   CLR_DONE  out  one-cycle pulse after the last word has been cleared
// ---------------------------------------------------------------------------
module dist_ram_mp #(
   parameter int                         WIDTH           = 4,
   parameter int                         DEPTH           = 64,
   parameter int                         NRD             = 4,
   parameter int                         OUT_REG         = 0,
   parameter int                         WRITE_FIRST     = 0,
   parameter logic [DEPTH*WIDTH-1:0]     INIT            = '0,
   parameter logic [WIDTH-1:0]           CLR_VALUE       = '0,
   parameter logic                       IS_CLK_INVERTED = 1'b0
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            WE,
   input  logic [$clog2(DEPTH)-1:0]        WADDR,
   input  logic [WIDTH-1:0]                DI,
   input  logic [NRD*$clog2(DEPTH)-1:0]    RADDR,
   output logic [NRD*WIDTH-1:0]            DO,
   input  logic                            CLR_REQ,
   output logic                            CLR_BUSY,
   output logic                            CLR_DONE
);

   localparam int            AW        = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam bit            BYPASS    = (WRITE_FIRST != 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } clr_state_t;

   // The XOR folds into the clock buffer/flop clock inversion on the device,
   // so every flop below simply uses posedge of clk_int.
   logic clk_int;
   assign clk_int = CLK ^ IS_CLK_INVERTED;

   clr_state_t       state;
   logic [AW-1:0]    cnt;
   logic             busy_q;
   logic             done_q;

   // Clear engine. busy_q/done_q are kept as registered copies of the state
   // so CLR_BUSY/CLR_DONE come straight from flops. The sweep counter stops
   // on the last address and hands over to DONE for exactly one cycle;
   // CLR_REQ is only looked at in IDLE, so a held request restarts a sweep
   // one cycle after DONE rather than immediately.
   always_ff @(posedge clk_int or posedge RST) begin
      if (RST) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (CLR_REQ) begin
                  state  <= ST_CLEAR;
                  cnt    <= '0;
                  busy_q <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (cnt == LAST_ADDR) begin
                  state  <= ST_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               done_q <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign CLR_BUSY = busy_q;
   assign CLR_DONE = done_q;

   // Single physical write port shared between the user and the clear
   // engine. While sweeping, the engine owns the port and user writes are
   // dropped; the read bypass below uses these same signals so sweep writes
   // are forwarded exactly like user writes.
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;

   always_comb begin
      wr_en   = WE;
      wr_addr = WADDR;
      wr_data = DI;
      if (busy_q) begin
         wr_en   = 1'b1;
         wr_addr = cnt;
         wr_data = CLR_VALUE;
      end
   end

   function automatic logic [WIDTH-1:0] init_word(input logic [AW-1:0] a);
      return INIT[int'(a)*WIDTH +: WIDTH];
   endfunction

   // The LUT array stores each word XORed with its INIT value. The array
   // itself therefore powers up at all zeros (the device default for LUT
   // RAM), needs no initialiser, and still reads back INIT before the first
   // write. There is deliberately no reset here: RST never touches contents.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_int) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data ^ init_word(wr_addr);
      end
   end

   // Per-port asynchronous read plus the value the optional output register
   // should capture (bypassed write data on an address hit in write-first
   // mode, otherwise the pre-write array contents).
   logic [NRD*WIDTH-1:0] rd_word;
   logic [NRD*WIDTH-1:0] nxt_word;
   logic [NRD*WIDTH-1:0] do_q;

   for (genvar k = 0; k < NRD; k++) begin : g_port
      logic [AW-1:0] ra;
      assign ra = RADDR[k*AW +: AW];
      assign rd_word[k*WIDTH +: WIDTH]  = mem[ra] ^ init_word(ra);
      assign nxt_word[k*WIDTH +: WIDTH] = (BYPASS && wr_en && (wr_addr == ra))
                                          ? wr_data
                                          : rd_word[k*WIDTH +: WIDTH];
   end

   // Registered read stage. When OUT_REG=0 nothing observes do_q and the
   // flops are trimmed away.
   always_ff @(posedge clk_int or posedge RST) begin
      if (RST) begin
         do_q <= '0;
      end else begin
         do_q <= nxt_word;
      end
   end

   assign DO = (OUT_REG != 0) ? do_q : rd_word;

endmodule

// File: tb/tb_dist_ram_mp.sv
// ---------------------------------------------------------------------------
// tb_dist_ram_mp
//
// Self-checking bench for dist_ram_mp. Three 64x4, 4-port instances share
// one stimulus stream (asynchronous read, registered write-first,
// registered read-first); a fourth 32x8 single-port instance runs on the
// falling clock edge with distinct INIT bytes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dist_ram_mp;

   localparam logic [3:0] CV  = 4'hF;
   localparam logic [7:0] CV8 = 8'h5A;

   function automatic logic [255:0] make_init8();
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[i*8 +: 8] = 8'((i * 7 + 3) % 256);
      return r;
   endfunction

   localparam logic [255:0] INIT8 = make_init8();

   logic        clk = 1'b0;
   logic        rst;

   logic        we;
   logic [5:0]  waddr;
   logic [3:0]  di;
   logic [23:0] raddr;
   logic        clr_req;
   logic [15:0] do_a, do_b, do_c;
   logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;

   logic        we_d;
   logic [4:0]  waddr_d;
   logic [7:0]  di_d;
   logic [4:0]  raddr_d;
   logic [7:0]  do_d;
   logic        clr_d;
   logic        busy_d, done_d;

   always #5 clk = ~clk;

   dist_ram_mp #(.OUT_REG(0), .CLR_VALUE(CV)) u_a (
      .CLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .DI(di), .RADDR(raddr),
      .DO(do_a), .CLR_REQ(clr_req), .CLR_BUSY(busy_a), .CLR_DONE(done_a));

   dist_ram_mp #(.OUT_REG(1), .WRITE_FIRST(1), .CLR_VALUE(CV)) u_b (
      .CLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .DI(di), .RADDR(raddr),
      .DO(do_b), .CLR_REQ(clr_req), .CLR_BUSY(busy_b), .CLR_DONE(done_b));

   dist_ram_mp #(.OUT_REG(1), .WRITE_FIRST(0), .CLR_VALUE(CV)) u_c (
      .CLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .DI(di), .RADDR(raddr),
      .DO(do_c), .CLR_REQ(clr_req), .CLR_BUSY(busy_c), .CLR_DONE(done_c));

   dist_ram_mp #(.WIDTH(8), .DEPTH(32), .NRD(1), .OUT_REG(0), .INIT(INIT8),
                 .CLR_VALUE(CV8), .IS_CLK_INVERTED(1'b1)) u_d (
      .CLK(clk), .RST(rst), .WE(we_d), .WADDR(waddr_d), .DI(di_d),
      .RADDR(raddr_d), .DO(do_d), .CLR_REQ(clr_d), .CLR_BUSY(busy_d),
      .CLR_DONE(done_d));

   // Reference model: word contents, sweep position (-1 = not sweeping),
   // the one-cycle done phase and the expected registered outputs.
   logic [3:0]  ref_mem [64];
   int          sweep_idx;
   bit          in_done;
   logic [15:0] ref_b, ref_c;

   int checks;
   int failures;
   int busy_cycles;
   int done_seen;
   int n;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [15:0] ref_read(input logic [23:0] ra);
      logic [15:0] r;
      for (int k = 0; k < 4; k++) r[k*4 +: 4] = ref_mem[ra[k*6 +: 6]];
      return r;
   endfunction

   // One clock cycle on the shared 64x4 instances: drive inputs, check the
   // asynchronous read before the edge, advance the model across the edge,
   // then check every output after it.
   task automatic applyStimulus(input logic we_i, input logic [5:0] waddr_i,
                                input logic [3:0] di_i, input logic [23:0] raddr_i,
                                input logic clr_i);
      logic       wr_ok;
      logic [5:0] wa;
      logic [3:0] wd;
      logic [5:0] ra_k;
      bit         was_done;
      we = we_i; waddr = waddr_i; di = di_i; raddr = raddr_i; clr_req = clr_i;
      #1;
      checkOutput("async_read_pre_edge", 64'(do_a), 64'(ref_read(raddr_i)));
      wr_ok = 1'b0; wa = '0; wd = '0;
      if (sweep_idx >= 0) begin
         wr_ok = 1'b1; wa = 6'(sweep_idx); wd = CV;
      end else if (we_i) begin
         wr_ok = 1'b1; wa = waddr_i; wd = di_i;
      end
      for (int k = 0; k < 4; k++) begin
         ra_k = raddr_i[k*6 +: 6];
         ref_c[k*4 +: 4] = ref_mem[ra_k];
         ref_b[k*4 +: 4] = (wr_ok && wa == ra_k) ? wd : ref_mem[ra_k];
      end
      if (wr_ok) ref_mem[wa] = wd;
      was_done = in_done;
      if (sweep_idx >= 0) begin
         if (sweep_idx == 63) begin
            sweep_idx = -1;
            in_done   = 1'b1;
         end else begin
            sweep_idx++;
         end
      end else if (was_done) begin
         in_done = 1'b0;
      end else if (clr_i) begin
         sweep_idx = 0;
      end
      @(posedge clk); #1;
      checkOutput("clr_busy", 64'(busy_a), 64'(sweep_idx >= 0));
      checkOutput("clr_done", 64'(done_a), 64'(in_done));
      checkOutput("reg_flags", 64'({busy_b, done_b, busy_c, done_c}),
                  64'({sweep_idx >= 0, in_done, sweep_idx >= 0, in_done}));
      checkOutput("async_read_post_edge", 64'(do_a), 64'(ref_read(raddr_i)));
      checkOutput("reg_read_write_first", 64'(do_b), 64'(ref_b));
      checkOutput("reg_read_read_first", 64'(do_c), 64'(ref_c));
   endtask

   // Reads every word through the four asynchronous ports, either against
   // the model or against the clear fill value.
   task automatic checkAllWords(input bit expect_fill);
      logic [23:0] ra;
      we = 1'b0; clr_req = 1'b0;
      for (int base = 0; base < 64; base += 4) begin
         ra = {6'(base + 3), 6'(base + 2), 6'(base + 1), 6'(base)};
         raddr = ra;
         #1;
         if (expect_fill) checkOutput("word_fill", 64'(do_a), 64'({4{CV}}));
         else             checkOutput("word_model", 64'(do_a), 64'(ref_read(ra)));
      end
      @(posedge clk); #1;
   endtask

   // Asserts RST between edges, checks the asynchronous effect, holds it for
   // two edges and releases it.
   task automatic pulseReset();
      we = 1'b0; clr_req = 1'b0; we_d = 1'b0; clr_d = 1'b0;
      rst = 1'b1;
      #1;
      sweep_idx = -1; in_done = 1'b0; ref_b = '0; ref_c = '0;
      checkOutput("rst_busy_async", 64'(busy_a), 64'(0));
      checkOutput("rst_do_reg_async", 64'({do_b, do_c}), 64'(0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("rst_do_reg_held", 64'({do_b, do_c}), 64'(0));
      checkOutput("rst_done_held", 64'(done_a), 64'(0));
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1;
      we = 1'b0; waddr = '0; di = '0; raddr = '0; clr_req = 1'b0;
      we_d = 1'b0; waddr_d = '0; di_d = '0; raddr_d = '0; clr_d = 1'b0;
      for (int i = 0; i < 64; i++) ref_mem[i] = 4'h0;
      sweep_idx = -1; in_done = 1'b0; ref_b = '0; ref_c = '0;
      #2;
      checkOutput("reset_do_reg", 64'({do_b, do_c}), 64'(0));
      checkOutput("reset_flags", 64'({busy_a, done_a, busy_d, done_d}), 64'(0));
      checkOutput("reset_init_read", 64'(do_a), 64'(0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      $display("[TB] reset released");

      // Falling-edge 32x8 instance: INIT bytes, write timing, clear sweep.
      for (int i = 0; i < 32; i++) begin
         raddr_d = 5'(i);
         #1;
         checkOutput("init8_word", 64'(do_d), 64'((i * 7 + 3) % 256));
      end
      @(posedge clk); #1;
      we_d = 1'b1; waddr_d = 5'd9; di_d = 8'hC3; raddr_d = 5'd9;
      #2;
      checkOutput("neg_write_before_negedge", 64'(do_d), 64'(8'h42));
      @(negedge clk); #1;
      checkOutput("neg_write_after_negedge", 64'(do_d), 64'(8'hC3));
      we_d = 1'b0;
      @(posedge clk); #1;
      clr_d = 1'b1;
      #2;
      checkOutput("neg_clr_before_negedge", 64'(busy_d), 64'(0));
      @(negedge clk); #1;
      clr_d = 1'b0;
      checkOutput("neg_clr_after_negedge", 64'(busy_d), 64'(1));
      busy_cycles = 1; done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (busy_d) busy_cycles++;
         if (done_d) done_seen++;
      end
      checkOutput("neg_clr_busy_len", 64'(busy_cycles), 64'(32));
      checkOutput("neg_clr_done_pulses", 64'(done_seen), 64'(1));
      for (int i = 0; i < 32; i++) begin
         raddr_d = 5'(i);
         #1;
         checkOutput("neg_clr_word", 64'(do_d), 64'(CV8));
      end
      @(posedge clk); #1;

      // Basic writes and same-cycle read behaviour.
      applyStimulus(1'b1, 6'd5, 4'hA, {6'd63, 6'd5, 6'd5, 6'd0}, 1'b0);
      applyStimulus(1'b1, 6'd63, 4'h3, {6'd63, 6'd5, 6'd5, 6'd0}, 1'b0);
      checkOutput("multi_port_read", 64'(do_a), 64'(16'h3AA0));
      we = 1'b1; waddr = 6'd5; di = 4'h7; raddr = {6'd63, 6'd5, 6'd5, 6'd0};
      #1;
      checkOutput("same_cycle_old_data", 64'(do_a[7:4]), 64'(4'hA));
      applyStimulus(1'b1, 6'd5, 4'h7, {6'd63, 6'd5, 6'd5, 6'd0}, 1'b0);
      checkOutput("read_after_write", 64'(do_a[7:4]), 64'(4'h7));

      // Registered read, write-first versus read-first.
      applyStimulus(1'b1, 6'd12, 4'h2, 24'(12), 1'b0);
      applyStimulus(1'b1, 6'd12, 4'h9, 24'(12), 1'b0);
      checkOutput("write_first_bypass", 64'(do_b[3:0]), 64'(4'h9));
      checkOutput("read_first_old", 64'(do_c[3:0]), 64'(4'h2));
      applyStimulus(1'b0, 6'd0, 4'h0, 24'(12), 1'b0);
      checkOutput("read_first_next", 64'(do_c[3:0]), 64'(4'h9));

      // Random traffic, then every word filled with non-fill data.
      for (int i = 0; i < 60; i++)
         applyStimulus(1'($urandom_range(0, 1)), 6'($urandom), 4'($urandom),
                       24'($urandom), 1'b0);
      for (int i = 0; i < 64; i++)
         applyStimulus(1'b1, 6'(i), 4'($urandom_range(0, 14)), 24'($urandom), 1'b0);

      // Reset after 20 sweep writes leaves a partially cleared array.
      applyStimulus(1'b0, 6'd0, 4'h0, 24'($urandom), 1'b1);
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b0, 6'd0, 4'h0, 24'($urandom), 1'b0);
      pulseReset();
      raddr = {6'd21, 6'd20, 6'd19, 6'd0};
      #1;
      checkOutput("partial_clear_edge", 64'({do_a[7:0]}), 64'({CV, CV}));
      checkOutput("partial_clear_kept", 64'(do_a[11:8] == CV || do_a[15:12] == CV), 64'(0));
      checkAllWords(1'b0);

      // Full sweep; a user write to address 3 while busy must be lost.
      applyStimulus(1'b0, 6'd0, 4'h0, 24'($urandom), 1'b1);
      busy_cycles = busy_a ? 1 : 0; done_seen = 0;
      for (int i = 0; i < 70; i++) begin
         applyStimulus(i == 10, 6'd3, 4'h0, 24'($urandom), 1'b0);
         if (busy_a) busy_cycles++;
         if (done_a) done_seen++;
      end
      checkOutput("sweep_busy_len", 64'(busy_cycles), 64'(64));
      checkOutput("sweep_done_pulses", 64'(done_seen), 64'(1));
      checkAllWords(1'b1);

      // Request held through DONE; write during DONE is cleared again.
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, 6'(i), 4'($urandom_range(0, 14)), 24'($urandom), 1'b0);
      applyStimulus(1'b0, 6'd0, 4'h0, 24'($urandom), 1'b1);
      n = 0;
      while (!done_a && n < 80) begin
         applyStimulus(1'b0, 6'd0, 4'h0, 24'($urandom), 1'b1);
         n++;
      end
      checkOutput("held_req_done_seen", 64'(done_a), 64'(1));
      applyStimulus(1'b1, 6'd7, 4'h5, 24'(7), 1'b1);
      checkOutput("done_cycle_write", 64'(do_a[3:0]), 64'(4'h5));
      checkOutput("restart_gap_idle", 64'(busy_a), 64'(0));
      applyStimulus(1'b0, 6'd0, 4'h0, 24'(7), 1'b1);
      checkOutput("restart_second_sweep", 64'(busy_a), 64'(1));
      for (int i = 0; i < 70; i++)
         applyStimulus(1'b0, 6'd0, 4'h0, 24'($urandom), 1'b0);
      checkAllWords(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dist_ram_mp.md
Name: dist_ram_mp

Overview:
- Parametrised multi-read-port distributed (LUT) RAM with one synchronous write port and NRD read ports.
- Adds an optional registered output stage with a selectable collision policy, and a hardware clear engine that sweeps the array with a fill value.
- Used for register files, small lookup tables and descriptor stores.
- Targets Xilinx FPGAs and builds under Verilator.

Parameters:
- WIDTH, 4, data bits per word (1..64)
- DEPTH, 64, number of words (2..256, power of two)
- AW, log2(DEPTH), address width (derived localparam, not overridable)
- NRD, 4, number of read ports (1..8)
- OUT_REG, 0, 0 = asynchronous read; 1 = read data registered on CLK
- WRITE_FIRST, 0, OUT_REG=1 only: 1 = same-cycle write to the read address is bypassed into DO; 0 = old data is registered
- INIT, {DEPTH*WIDTH{1'b0}}, power-up contents; word i at bits [i*WIDTH +: WIDTH]
- CLR_VALUE, {WIDTH{1'b0}}, word written by the clear engine
- IS_CLK_INVERTED, 1'b0, 1 = all sequential logic uses negedge CLK

Ports:
- CLK  in  1  clock; the single clock for the block
- RST  in  1  asynchronous, active-high reset
- WE  in  1  write enable
- WADDR  in  AW  write address
- DI  in  WIDTH  write data
- RADDR  in  NRD*AW  read addresses; port k at [k*AW +: AW]
- DO  out  NRD*WIDTH  read data; port k at [k*WIDTH +: WIDTH]
- CLR_REQ  in  1  clear request, level-sampled
- CLR_BUSY  out  1  clear engine active
- CLR_DONE  out  1  one-cycle pulse after the last word is cleared

Behaviour:

Memory array
- No reset on the array. Power-up contents are INIT; RST does not alter them.
- Write: on the active CLK edge with WE=1 and CLR_BUSY=0, mem[WADDR] <= DI.
- WE is ignored while CLR_BUSY=1; no queuing, the write is lost.

Read path
- OUT_REG=0: DO[k] = mem[RADDR[k]], combinational.
  - A write becomes visible after the edge that performs it; same-cycle read returns old data.
- OUT_REG=1: DO[k] is registered on the active edge, latency 1.
  - DO resets to all zeros while RST=1.
  - WRITE_FIRST=1 and accepted write with WADDR==RADDR[k]: register captures DI.
  - Otherwise the register captures the pre-write mem[RADDR[k]].
  - Clear-engine writes follow the same bypass rule, using the sweep address and CLR_VALUE.
- Any number of ports may read the same address in the same cycle with no conflict.

Clear engine FSM (state and counter reset asynchronously to IDLE / 0)
- IDLE:
  - CLR_BUSY=0.
  - CLR_REQ=1 sampled on an edge -> CLEAR with cnt=0.
  - A user WE in the same cycle as the request is still accepted.
- CLEAR:
  - CLR_BUSY=1.
  - Each edge: mem[cnt] <= CLR_VALUE, cnt <= cnt+1.
  - When cnt==DEPTH-1 the write occurs, then -> DONE.
  - Sweep length is exactly DEPTH cycles.
  - CLR_REQ is ignored while in CLEAR.
- DONE:
  - One cycle; CLR_BUSY=0, CLR_DONE=1; user writes are accepted this cycle.
  - -> IDLE. A CLR_REQ held high restarts a clear from IDLE on the following edge.
- Reset outputs: CLR_BUSY=0, CLR_DONE=0.
- RST asserted mid-clear: sweep aborts immediately and the array stays partially cleared (words 0..cnt-1 = CLR_VALUE). No CLR_DONE pulse. After RST deasserts the FSM is in IDLE.
- cnt is AW bits wide. The terminal compare uses DEPTH-1; no wrap beyond it.

Test Plan:
1. Defaults, OUT_REG=0, INIT=0: write 4'hA to addr 5, 4'h3 to addr 63 -> RADDR={63,5,5,0} gives DO={3,A,A,0}. Same-cycle read of addr 5 during the write of 4'h7 returns 4'hA, then 4'h7 after the edge.
2. OUT_REG=1, WRITE_FIRST=1 vs 0: write 4'h9 to addr 12 while RADDR[0]=12 (old 4'h2) -> DO[0]=4'h9 one cycle later when WRITE_FIRST=1, 4'h2 when 0. DO=0 during RST.
3. Clear sweep with DEPTH=64, CLR_VALUE=4'hF: pulse CLR_REQ -> CLR_BUSY high for exactly 64 cycles, then CLR_DONE pulses once. All 64 words read 4'hF. A WE to addr 3 during busy has no effect.
4. Reset mid-clear: assert RST at sweep cycle 20 -> words 0..19 = CLR_VALUE, words 20..63 unchanged. CLR_BUSY=0 asynchronously, no CLR_DONE; a new CLR_REQ after RST completes a full sweep.
5. CLR_REQ held high through DONE -> second sweep starts two cycles after the first CLR_DONE. Write accepted in the DONE cycle: the word is cleared again by the second sweep.
6. Parameter sweep WIDTH=8, DEPTH=32, NRD=1 and IS_CLK_INVERTED=1: writes and clear occur on negedge CLK. INIT=32 distinct bytes are readable after RST with no writes.
